// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with one outstanding icache
// request, a small {pc, instr} FIFO toward decode, and redirect handling
// that flushes the queue and discards any response already in flight.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int WORDSZ = 64,
    parameter int INSTSZ = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WORDSZ-1:0]          entry,
    input  logic                       redirect_valid,
    input  logic [WORDSZ-1:0]          redirect_pc,
    output logic                       icache_req,
    output logic [WORDSZ-1:0]          icache_addr,
    input  logic                       icache_resp_valid,
    input  logic [INSTSZ-1:0]          icache_resp_instr,
    output logic                       dec_valid,
    output logic [INSTSZ-1:0]          dec_instr,
    output logic [WORDSZ-1:0]          dec_pc,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WORDSZ-1:0] fetch_pc;
    logic [WORDSZ-1:0] req_addr;
    logic [WORDSZ-1:0] pc_mem    [DEPTH];
    logic [INSTSZ-1:0] instr_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [OW-1:0]     count;
    logic              issue;
    logic              push;
    logic              pop;

    // Redirect targets are word aligned; the low two bits are ignored.
    logic [WORDSZ-1:0] redirect_aligned;
    assign redirect_aligned = {redirect_pc[WORDSZ-1:2], 2'b00};

    // Decode sees the head entry directly; an empty queue presents zeros.
    assign dec_valid   = (count != '0);
    assign dec_pc      = dec_valid ? pc_mem[rd_ptr]    : '0;
    assign dec_instr   = dec_valid ? instr_mem[rd_ptr] : '0;
    assign occupancy   = count;

    // The request stays up through DISCARD because the icache cannot abort;
    // req_addr keeps the old address even after fetch_pc is retargeted.
    assign icache_req  = (state != FETCH);
    assign icache_addr = req_addr;

    // A redirect cancels any pop in the same cycle.
    assign pop = dec_valid && dec_ready && !redirect_valid;

    // Next-state logic: issue when there is room, retire or drop responses.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        unique case (state)
            FETCH: begin
                if (!redirect_valid && count < FULL) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    // A response arriving with the redirect retires the request.
                    state_next = icache_resp_valid ? FETCH : DISCARD;
                end else if (icache_resp_valid) begin
                    push       = 1'b1;
                    state_next = FETCH;
                end
            end
            DISCARD: begin
                // The stale response ends the discard even if another redirect
                // arrives with it; otherwise we would wait for a reply that
                // will never come.
                if (icache_resp_valid) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Control registers: state, fetch PC, request address, FIFO pointers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= {entry[WORDSZ-1:2], 2'b00};
            req_addr <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                req_addr <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + WORDSZ'(4);
                    wr_ptr   <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (!push && pop) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // FIFO storage: written on push, read combinationally at the head.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy alone
        // decides which entries are meaningful, and empty reads are masked.
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= icache_resp_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus with a scoreboard. The
// reference model says that after reset or redirect to T, decode must see
// T, T+4, T+8 ... (wrapping at 2^64) with instr = mem_word(pc), in order.
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int WORDSZ = 64;
    localparam int INSTSZ = 32;
    localparam int OW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [WORDSZ-1:0] entry;
    logic              redirect_valid;
    logic [WORDSZ-1:0] redirect_pc;
    logic              icache_req;
    logic [WORDSZ-1:0] icache_addr;
    logic              icache_resp_valid;
    logic [INSTSZ-1:0] icache_resp_instr;
    logic              dec_valid;
    logic [INSTSZ-1:0] dec_instr;
    logic [WORDSZ-1:0] dec_pc;
    logic              dec_ready;
    logic [OW-1:0]     occupancy;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .WORDSZ(WORDSZ), .INSTSZ(INSTSZ)) dut (
        .clk               (clk),
        .reset             (reset),
        .entry             (entry),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .icache_req        (icache_req),
        .icache_addr       (icache_addr),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_instr (icache_resp_instr),
        .dec_valid         (dec_valid),
        .dec_instr         (dec_instr),
        .dec_pc            (dec_pc),
        .dec_ready         (dec_ready),
        .occupancy         (occupancy)
    );

    typedef struct {
        logic [WORDSZ-1:0] pc;
        logic [INSTSZ-1:0] instr;
    } pair_t;

    pair_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    pops     = 0;
    bit    armed    = 1'b0;

    // icache model state
    bit                ic_busy = 1'b0;
    logic [WORDSZ-1:0] ic_addr;
    int                ic_wait;

    function automatic logic [INSTSZ-1:0] mem_word(input logic [WORDSZ-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected decode stream starting at an (aligned) target.
    task automatic start_stream(input logic [WORDSZ-1:0] target);
        logic [WORDSZ-1:0] pc;
        pc = {target[WORDSZ-1:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 4096; i++) begin
            exp_q.push_back('{pc, mem_word(pc)});
            pc = pc + 64'd4;
        end
    endtask

    // One clock of stimulus, called #1 after a posedge.
    // ready_mode: 0 low, 1 high, 2 random 70%, 3 only when a response is returned.
    task automatic step(input int ready_mode, input int lat_lo, input int lat_hi,
                        input int redir_pct, input bit force_redir,
                        input logic [WORDSZ-1:0] force_target);
        bit do_redir;
        icache_resp_valid = 1'b0;
        if (icache_req) begin
            if (!ic_busy) begin
                ic_busy = 1'b1;
                ic_addr = icache_addr;
                ic_wait = int'($urandom_range(lat_hi, lat_lo));
            end else begin
                check("icache_addr_stable", icache_addr, ic_addr);
            end
            if (ic_wait == 0) begin
                icache_resp_valid = 1'b1;
                icache_resp_instr = mem_word(ic_addr);
                ic_busy           = 1'b0;
            end else begin
                ic_wait--;
            end
        end
        case (ready_mode)
            0:       dec_ready = 1'b0;
            1:       dec_ready = 1'b1;
            2:       dec_ready = ($urandom_range(99, 0) < 70);
            default: dec_ready = icache_resp_valid;
        endcase
        do_redir = force_redir || (int'($urandom_range(99, 0)) < redir_pct);
        redirect_valid = do_redir;
        if (do_redir) begin
            if (force_redir) begin
                redirect_pc = force_target;
            end else begin
                case ($urandom_range(3, 0))
                    0:       redirect_pc = 64'h0000_0000_0000_3002;
                    1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF1;
                    2:       redirect_pc = {$urandom, $urandom};
                    default: redirect_pc = 64'h8000 + 64'($urandom_range(255, 0));
                endcase
            end
            start_stream(redirect_pc);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (do_redir) begin
            check("redirect_flush_occ", 64'(occupancy), 64'd0);
            check("redirect_flush_valid", 64'(dec_valid), 64'd0);
        end
    endtask

    // One-cycle synchronous reset with a new entry PC, then reset-state checks.
    task automatic do_reset(input logic [WORDSZ-1:0] new_entry);
        reset             = 1'b1;
        entry             = new_entry;
        redirect_valid    = 1'b0;
        icache_resp_valid = 1'b0;
        dec_ready         = 1'b0;
        ic_busy           = 1'b0;
        @(posedge clk);
        #1;
        check("rst_icache_req", 64'(icache_req), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_dec_pc", dec_pc, 64'd0);
        check("rst_dec_instr", 64'(dec_instr), 64'd0);
        start_stream(new_entry);
        reset = 1'b0;
    endtask

    // Monitor: sampled on the falling edge, it pops the scoreboard for every
    // handshake that will complete at the next rising edge.
    always @(negedge clk) begin : monitor
        pair_t             e;
        bit                hold_pending;
        logic [WORDSZ-1:0] held_pc;
        if (armed && !reset) begin
            check("valid_vs_occupancy", 64'(dec_valid), 64'(occupancy != '0));
            if (hold_pending && dec_valid) begin
                check("head_hold", dec_pc, held_pc);
            end
            hold_pending = dec_valid && !dec_ready && !redirect_valid;
            held_pc      = dec_pc;
            if (dec_valid && dec_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: pop at pc %h with no expected entry", dec_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_pc", dec_pc, e.pc);
                    check("dec_instr", 64'(dec_instr), 64'(e.instr));
                    pops++;
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin : driver
        int start_pops;
        reset             = 1'b1;
        entry             = 64'h1000;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        icache_resp_valid = 1'b0;
        icache_resp_instr = '0;
        dec_ready         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(64'h1000);
        armed = 1'b1;

        // Sequential fetch, single-cycle icache, decode always ready.
        start_pops = pops;
        repeat (30) step(1, 0, 0, 0, 1'b0, '0);
        check("seq_progress", 64'(pops - start_pops >= 10), 64'd1);

        // Decode stalled: queue fills and fetching stops.
        do_reset(64'h2000);
        repeat (30) step(0, 0, 2, 0, 1'b0, '0);
        check("full_occupancy", 64'(occupancy), 64'(DEPTH));
        check("full_no_req", 64'(icache_req), 64'd0);
        check("full_head_pc", dec_pc, 64'h2000);
        check("full_head_instr", 64'(dec_instr), 64'(mem_word(64'h2000)));
        repeat (20) step(1, 0, 0, 0, 1'b0, '0);

        // Redirect while waiting on a late response.
        for (int i = 0; i < 10 && !icache_req; i++) step(1, 5, 5, 0, 1'b0, '0);
        check("late_req_seen", 64'(icache_req), 64'd1);
        step(1, 5, 5, 0, 1'b1, 64'h3002);
        repeat (30) step(1, 0, 0, 0, 1'b0, '0);

        // Redirect in the same cycle as a response, with a poppable head.
        do_reset(64'h3800);
        repeat (4) step(0, 0, 0, 0, 1'b0, '0);
        for (int i = 0; i < 4 && !icache_req; i++) step(0, 0, 0, 0, 1'b0, '0);
        check("same_cycle_req", 64'(icache_req), 64'd1);
        check("same_cycle_head", 64'(dec_valid), 64'd1);
        step(1, 0, 0, 0, 1'b1, 64'h4000);
        step(1, 0, 0, 0, 1'b0, '0);
        check("retarget_req", 64'(icache_req), 64'd1);
        check("retarget_addr", icache_addr, 64'h4000);
        repeat (20) step(1, 0, 0, 0, 1'b0, '0);

        // Occupancy 3 with push and pop together; pointers wrap repeatedly.
        do_reset(64'h5000);
        for (int i = 0; i < 20 && occupancy != 3; i++) step(0, 0, 0, 0, 1'b0, '0);
        check("occ3_reached", 64'(occupancy), 64'd3);
        for (int i = 0; i < 22; i++) begin
            step(3, 0, 0, 0, 1'b0, '0);
            check("occ3_steady", 64'(occupancy), 64'd3);
        end
        repeat (12) step(1, 0, 0, 0, 1'b0, '0);

        // Reset while waiting with two entries queued.
        do_reset(64'h6000);
        for (int i = 0; i < 40 && !(occupancy == 2 && icache_req); i++) step(0, 3, 3, 0, 1'b0, '0);
        check("wait_two_queued", 64'(occupancy == 2 && icache_req), 64'd1);
        do_reset(64'h7000);
        repeat (20) step(1, 0, 0, 0, 1'b0, '0);

        // Randomized traffic: latency, stalls, redirects and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199, 0) == 0) begin
                do_reset({32'h0, $urandom});
            end else begin
                step(2, 0, 4, 3, 1'b0, '0);
            end
        end

        check("total_progress", 64'(pops >= 300), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Sits between the instruction cache and the register/decode stage, directly upstream of decode.
- Generates sequential fetch addresses, holds the icache request handshake, and buffers returned {pc, instruction} pairs in a small FIFO.
- Decode drains the FIFO through a valid/ready interface, so icache latency is decoupled from decode stalls.
- Handles PC redirects from a taken branch or a flush: the queue is flushed, and any response already in flight is discarded.

Parameters:
- DEPTH, 4: FIFO entries. Must be a power of two, at least 2.
- WORDSZ, 64: PC/address width.
- INSTSZ, 32: instruction width.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- entry  input  WORDSZ  PC loaded while reset is high
- redirect_valid  input  1  one-cycle redirect request (taken jump or flush)
- redirect_pc  input  WORDSZ  new fetch PC; bits [1:0] ignored (treated as 0)
- icache_req  output  1  fetch request, held high until icache_resp_valid
- icache_addr  output  WORDSZ  fetch address, stable while icache_req is high
- icache_resp_valid  input  1  one-cycle pulse: instruction returned for icache_addr
- icache_resp_instr  input  INSTSZ  returned instruction
- dec_valid  output  1  FIFO head is valid
- dec_instr  output  INSTSZ  head instruction
- dec_pc  output  WORDSZ  PC of head instruction
- dec_ready  input  1  decode accepts the head this cycle
- occupancy  output  $clog2(DEPTH+1)  number of valid FIFO entries

Behaviour:
- All state is registered on posedge clk.
- Reset:
  - fetch_pc <= {entry[WORDSZ-1:2], 2'b00}; FIFO empty; occupancy = 0; state = FETCH.
  - Outputs during and after reset: icache_req = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0.
  - Reset asserted mid-operation abandons any outstanding request. The icache is reset by the same signal.
- FSM states: FETCH, WAIT, DISCARD.
  - FETCH: when occupancy < DEPTH and no redirect this cycle, go to WAIT next cycle with icache_addr = fetch_pc. If the FIFO is full, stay in FETCH.
  - WAIT: icache_req = 1, icache_addr = fetch_pc.
    - On icache_resp_valid (no redirect): push {fetch_pc, icache_resp_instr}, fetch_pc += 4, go to FETCH.
    - One request outstanding at most. Space was checked at issue and the count cannot rise while waiting, so the push never overflows.
  - DISCARD: icache_req stays 1 with the old address, because the icache cannot abort. On icache_resp_valid, drop the data and go to FETCH.
- Redirect (redirect_valid = 1), highest priority:
  - FIFO flushed, so occupancy = 0 and dec_valid = 0 from the next cycle.
  - fetch_pc <= {redirect_pc[WORDSZ-1:2], 2'b00}.
  - From FETCH: go to FETCH. No request is issued in the redirect cycle.
  - From WAIT without resp_valid in the same cycle: go to DISCARD.
  - From WAIT with resp_valid in the same cycle: the response is dropped and the next state is FETCH.
  - From DISCARD: stay in DISCARD. The new target replaces fetch_pc.
  - A pop or push in the same cycle as a redirect is cancelled.
- FIFO:
  - Read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH. Occupancy counter is separate.
  - Pop when dec_valid && dec_ready.
  - Push and pop in the same cycle leaves occupancy unchanged.
  - Push into an empty FIFO becomes visible on dec_valid the next cycle; there is no bypass.
  - dec_instr/dec_pc come straight from the head entry. They hold their value while dec_valid && !dec_ready.
  - Pointers wrap cleanly at DEPTH-1 to 0.
- Throughput: one instruction per two cycles at best with a single-cycle icache (issue cycle + response cycle).
- fetch_pc wraps modulo 2^WORDSZ. No exception is raised.

Test Plan:
1. Reset with entry=0x1000, icache returns after 1 cycle with instr=0x00000013, dec_ready=1 → dec_pc sequence 0x1000, 0x1004, 0x1008; icache_addr never changes while icache_req=1.
2. dec_ready=0, responses 0xA0..0xA3 at PCs 0x2000..0x200C → occupancy reaches 4, icache_req stays 0 in FETCH; raising dec_ready pops 0xA0 first, and the head holds 0xA0 stable while stalled.
3. Redirect to 0x3002 while in WAIT with response 5 cycles late → FIFO empty next cycle; late response dropped; next icache_addr=0x3000; first dec_pc=0x3000.
4. redirect_valid and icache_resp_valid in the same cycle, plus dec_ready=1 with a valid head → nothing pushed, nothing popped, occupancy=0, next request to the redirect target with no DISCARD state.
5. Occupancy 3, push and pop in the same cycle, repeated 10 times → occupancy stays 3; pointers wrap; dec_pc order is strictly +4.
6. Reset asserted while in WAIT with 2 entries queued → next cycle icache_req=0, dec_valid=0, occupancy=0; fetching restarts at the new entry.
